// File: rtl/axi4_burst_slave.sv
// AXI4 leaf slave with an integrated word-organised memory.
// Independent read and write burst engines: FIXED/INCR/WRAP, byte strobes, per-beat SLVERR.
module axi4_burst_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int NB      = DATA_WIDTH / 8;
    localparam int NB_LOG2 = $clog2(NB);
    localparam int IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [ADDR_WIDTH:0]   addr_ext_t;

    localparam addr_t      DEPTH_A     = addr_t'(MEM_DEPTH);
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

    function automatic logic in_range(input addr_t addr);
        return (addr >> NB_LOG2) < DEPTH_A;
    endfunction

    // Burst-wide illegality: every beat of such a burst is answered with SLVERR.
    function automatic logic burst_illegal(input addr_t addr, input logic [7:0] len,
                                           input logic [2:0] size, input logic [1:0] burst);
        addr_t align_mask;
        logic  wrap_len_ok;
        align_mask  = (addr_t'(1) << size) - addr_t'(1);
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size > 3'(NB_LOG2)) || (burst == BURST_RSVD) ||
               ((burst == BURST_WRAP) && (!wrap_len_ok || ((addr & align_mask) != '0)));
    endfunction

    // MSB of the result is the carry out of the address space (treated as out-of-range).
    function automatic addr_ext_t next_addr(input addr_t addr, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
        addr_ext_t step, sum, span, base;
        step = addr_ext_t'(1) << size;
        sum  = {1'b0, addr} + step;
        span = (addr_ext_t'(len) + addr_ext_t'(1)) << size;
        base = {1'b0, addr} & ~(span - addr_ext_t'(1));
        case (burst)
            BURST_FIXED: next_addr = {1'b0, addr};
            BURST_WRAP:  next_addr = (sum == base + span) ? base : sum;
            default:     next_addr = sum;
        endcase
    endfunction

    // ---------------------------------------------------------------- write channel
    w_state_e   w_state_q, w_state_d;
    addr_t      w_addr_q, w_addr_d;
    logic [7:0] w_len_q, w_len_d;
    logic [2:0] w_size_q, w_size_d;
    logic [1:0] w_burst_q, w_burst_d;
    logic [8:0] w_cnt_q, w_cnt_d;
    logic       w_bad_q, w_bad_d;
    logic       w_ovf_q, w_ovf_d;
    logic       w_err_q, w_err_d;
    logic       aw_ready_q;
    logic       w_last_beat, w_beat_ok, mem_we;
    addr_ext_t  w_addr_nxt;

    assign w_last_beat = (w_cnt_q == {1'b0, w_len_q});
    assign w_beat_ok   = !w_bad_q && !w_ovf_q && in_range(w_addr_q);
    assign w_addr_nxt  = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
    assign mem_we      = ARESETn && (w_state_q == W_DATA) && WVALID && w_beat_ok;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_d = w_state_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_size_d  = w_size_q;
        w_burst_d = w_burst_q;
        w_cnt_d   = w_cnt_q;
        w_bad_d   = w_bad_q;
        w_ovf_d   = w_ovf_q;
        w_err_d   = w_err_q;
        case (w_state_q)
            W_IDLE: begin
                if (AWVALID && aw_ready_q) begin
                    w_addr_d  = AWADDR;
                    w_len_d   = AWLEN;
                    w_size_d  = AWSIZE;
                    w_burst_d = AWBURST;
                    w_cnt_d   = '0;
                    w_bad_d   = burst_illegal(AWADDR, AWLEN, AWSIZE, AWBURST);
                    w_ovf_d   = 1'b0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (WVALID) begin
                    w_cnt_d  = w_cnt_q + 9'd1;
                    w_addr_d = w_addr_nxt[ADDR_WIDTH-1:0];
                    if (w_addr_nxt[ADDR_WIDTH]) w_ovf_d = 1'b1;
                    // A misplaced WLAST only poisons the response; AWLEN still sets the length.
                    if (!w_beat_ok || (WLAST != w_last_beat)) w_err_d = 1'b1;
                    if (w_last_beat) w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (BREADY) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            w_state_q  <= W_IDLE;
            w_addr_q   <= '0;
            w_len_q    <= '0;
            w_size_q   <= '0;
            w_burst_q  <= '0;
            w_cnt_q    <= '0;
            w_bad_q    <= 1'b0;
            w_ovf_q    <= 1'b0;
            w_err_q    <= 1'b0;
            aw_ready_q <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            w_addr_q   <= w_addr_d;
            w_len_q    <= w_len_d;
            w_size_q   <= w_size_d;
            w_burst_q  <= w_burst_d;
            w_cnt_q    <= w_cnt_d;
            w_bad_q    <= w_bad_d;
            w_ovf_q    <= w_ovf_d;
            w_err_q    <= w_err_d;
            aw_ready_q <= (w_state_d == W_IDLE);
        end
    end

    assign AWREADY = aw_ready_q;
    assign WREADY  = (w_state_q == W_DATA);
    assign BVALID  = (w_state_q == W_RESP);
    assign BRESP   = (BVALID && w_err_q) ? RESP_SLVERR : RESP_OKAY;

    // ---------------------------------------------------------------- storage
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rd_mem_q;
    logic                  r_rd_en;
    addr_t                 r_addr_q, r_addr_d;

    // NOTE: the array and its read register carry no reset; contents survive ARESETn.
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (WSTRB[b]) mem_q[w_addr_q[NB_LOG2 +: IDX_W]][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
    end

    // Separate read port: a same-cycle write to the same word is seen only next time.
    always_ff @(posedge ACLK) begin
        if (r_rd_en) rd_mem_q <= mem_q[r_addr_q[NB_LOG2 +: IDX_W]];
    end

    // ---------------------------------------------------------------- read channel
    r_state_e   r_state_q, r_state_d;
    logic [7:0] r_len_q, r_len_d;
    logic [2:0] r_size_q, r_size_d;
    logic [1:0] r_burst_q, r_burst_d;
    logic [8:0] r_cnt_q, r_cnt_d;
    logic       r_bad_q, r_bad_d;
    logic       r_ovf_q, r_ovf_d;
    logic       r_err_q, r_err_d;
    logic       ar_ready_q;
    logic       r_last_beat, r_beat_ok;
    addr_ext_t  r_addr_nxt;

    assign r_last_beat = (r_cnt_q == {1'b0, r_len_q});
    assign r_beat_ok   = !r_bad_q && !r_ovf_q && in_range(r_addr_q);
    assign r_addr_nxt  = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
    assign r_rd_en     = (r_state_q == R_FETCH) && r_beat_ok;

    always_comb begin
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_cnt_d   = r_cnt_q;
        r_bad_d   = r_bad_q;
        r_ovf_d   = r_ovf_q;
        r_err_d   = r_err_q;
        case (r_state_q)
            R_IDLE: begin
                if (ARVALID && ar_ready_q) begin
                    r_addr_d  = ARADDR;
                    r_len_d   = ARLEN;
                    r_size_d  = ARSIZE;
                    r_burst_d = ARBURST;
                    r_cnt_d   = '0;
                    r_bad_d   = burst_illegal(ARADDR, ARLEN, ARSIZE, ARBURST);
                    r_ovf_d   = 1'b0;
                    r_state_d = R_FETCH;
                end
            end
            R_FETCH: begin
                r_err_d   = !r_beat_ok;
                r_state_d = R_DATA;
            end
            R_DATA: begin
                if (RREADY) begin
                    if (r_last_beat) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_cnt_d   = r_cnt_q + 9'd1;
                        r_addr_d  = r_addr_nxt[ADDR_WIDTH-1:0];
                        if (r_addr_nxt[ADDR_WIDTH]) r_ovf_d = 1'b1;
                        r_state_d = R_FETCH;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state_q  <= R_IDLE;
            r_addr_q   <= '0;
            r_len_q    <= '0;
            r_size_q   <= '0;
            r_burst_q  <= '0;
            r_cnt_q    <= '0;
            r_bad_q    <= 1'b0;
            r_ovf_q    <= 1'b0;
            r_err_q    <= 1'b0;
            ar_ready_q <= 1'b0;
        end else begin
            r_state_q  <= r_state_d;
            r_addr_q   <= r_addr_d;
            r_len_q    <= r_len_d;
            r_size_q   <= r_size_d;
            r_burst_q  <= r_burst_d;
            r_cnt_q    <= r_cnt_d;
            r_bad_q    <= r_bad_d;
            r_ovf_q    <= r_ovf_d;
            r_err_q    <= r_err_d;
            ar_ready_q <= (r_state_d == R_IDLE);
        end
    end

    assign ARREADY = ar_ready_q;
    assign RVALID  = (r_state_q == R_DATA);
    assign RDATA   = (RVALID && !r_err_q) ? rd_mem_q : '0;
    assign RRESP   = (RVALID && r_err_q) ? RESP_SLVERR : RESP_OKAY;
    assign RLAST   = RVALID && r_last_beat;

endmodule

// File: tb/tb_axi4_burst_slave.sv
// Directed self-checking bench for axi4_burst_slave (32-bit data, 16-bit address, 1024 words).
// Write/read bursts, WRAP order, strobes, range and legality errors, stalls, concurrency, mid-burst reset.
module tb_axi4_burst_slave;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [15:0] AWADDR, ARADDR;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST;
    logic        AWVALID, AWREADY, ARVALID, ARREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;
    logic        WLAST, WVALID, WREADY;
    logic [1:0]  BRESP, RRESP;
    logic        BVALID, BREADY, RLAST, RVALID, RREADY;

    int checks   = 0;
    int failures = 0;

    logic [31:0] wdata_v [16];
    logic [3:0]  wstrb_v [16];
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [31:0] exp_v   [4];
    logic [1:0]  resp, resp_c;

    axi4_burst_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_DEPTH(1024)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // last_beat: index of the beat carrying WLAST (len for a well-formed burst, -1 for never).
    task automatic axi_write(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input int last_beat, output logic [1:0] bresp_o);
        int t;
        AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        t = 0;
        while (AWREADY !== 1'b1 && t < 20) begin tick(); t++; end
        check("awready_wait", AWREADY, 1'b1);
        tick();
        AWVALID = 1'b0;
        check("wready_after_aw", WREADY, 1'b1);
        for (int i = 0; i <= int'(len); i++) begin
            WDATA = wdata_v[i]; WSTRB = wstrb_v[i]; WLAST = (i == last_beat); WVALID = 1'b1;
            t = 0;
            while (WREADY !== 1'b1 && t < 20) begin tick(); t++; end
            tick();
        end
        WVALID = 1'b0; WLAST = 1'b0;
        check("bvalid_after_last_w", BVALID, 1'b1);
        bresp_o = BRESP;
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
    endtask

    // stall_beat: beat index held with RREADY low for 3 cycles (-1 for none).
    task automatic axi_read(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input int stall_beat);
        int          t;
        logic [31:0] held_d;
        logic        held_l;
        ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        t = 0;
        while (ARREADY !== 1'b1 && t < 20) begin tick(); t++; end
        check("arready_wait", ARREADY, 1'b1);
        tick();
        ARVALID = 1'b0;
        check("rvalid_fetch_bubble", RVALID, 1'b0);
        for (int i = 0; i <= int'(len); i++) begin
            t = 0;
            while (RVALID !== 1'b1 && t < 20) begin tick(); t++; end
            check("rvalid_wait", RVALID, 1'b1);
            if (i == stall_beat) begin
                held_d = RDATA;
                held_l = RLAST;
                repeat (3) tick();
                check("stall_rvalid", RVALID, 1'b1);
                check("stall_rdata", RDATA, held_d);
                check("stall_rlast", RLAST, held_l);
            end
            rd_data[i] = RDATA; rd_resp[i] = RRESP; rd_last[i] = RLAST;
            RREADY = 1'b1;
            tick();
            RREADY = 1'b0;
        end
    endtask

    initial begin
        ARESETn = 1'b0;
        AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_awready", AWREADY, 1'b0);
        check("rst_arready", ARREADY, 1'b0);
        check("rst_wready", WREADY, 1'b0);
        check("rst_bvalid", BVALID, 1'b0);
        check("rst_rvalid", RVALID, 1'b0);
        check("rst_rlast", RLAST, 1'b0);
        check("rst_bresp", BRESP, 2'b00);
        check("rst_rresp", RRESP, 2'b00);
        check("rst_rdata", RDATA, 32'h0);
        ARESETn = 1'b1;
        tick();
        check("post_rst_awready", AWREADY, 1'b1);
        check("post_rst_arready", ARREADY, 1'b1);

        // INCR write/read at 0x010: words 4..7 = A0..A3
        for (int i = 0; i < 4; i++) begin wdata_v[i] = 32'hA0 + i; wstrb_v[i] = 4'hF; end
        axi_write(16'h010, 8'd3, 3'd2, 2'd1, 3, resp);
        check("incr_bresp", resp, 2'b00);
        axi_read(16'h010, 8'd3, 3'd2, 2'd1, -1);
        for (int i = 0; i < 4; i++) begin
            check("incr_rdata", rd_data[i], 32'hA0 + i);
            check("incr_rresp", rd_resp[i], 2'b00);
            check("incr_rlast", rd_last[i], i == 3);
        end

        // WRAP read from 0x018: container 0x010..0x01F
        exp_v[0] = 32'hA2; exp_v[1] = 32'hA3; exp_v[2] = 32'hA0; exp_v[3] = 32'hA1;
        axi_read(16'h018, 8'd3, 3'd2, 2'd2, -1);
        for (int i = 0; i < 4; i++) begin
            check("wrap_rdata", rd_data[i], exp_v[i]);
            check("wrap_rresp", rd_resp[i], 2'b00);
        end

        // FIXED write: last beat wins
        for (int i = 0; i < 4; i++) begin wdata_v[i] = 32'h1 + i; wstrb_v[i] = 4'hF; end
        axi_write(16'h020, 8'd3, 3'd2, 2'd0, 3, resp);
        check("fixed_bresp", resp, 2'b00);
        axi_read(16'h020, 8'd0, 3'd2, 2'd1, -1);
        check("fixed_rdata", rd_data[0], 32'h4);
        check("single_rlast", rd_last[0], 1'b1);

        // Byte strobes
        wdata_v[0] = 32'hFFFF_FFFF; wstrb_v[0] = 4'hF;
        axi_write(16'h024, 8'd0, 3'd2, 2'd1, 0, resp);
        wdata_v[0] = 32'h1122_3344; wstrb_v[0] = 4'h5;
        axi_write(16'h024, 8'd0, 3'd2, 2'd1, 0, resp);
        check("strb_bresp", resp, 2'b00);
        axi_read(16'h024, 8'd0, 3'd2, 2'd1, -1);
        check("strb_rdata", rd_data[0], 32'hFF22_FF44);

        // Burst crossing the top of memory: words 1022,1023 valid, 1024,1025 not
        for (int i = 0; i < 4; i++) begin wdata_v[i] = 32'hB0 + i; wstrb_v[i] = 4'hF; end
        axi_write(16'h0FF8, 8'd3, 3'd2, 2'd1, 3, resp);
        check("oor_bresp", resp, 2'b10);
        axi_read(16'h0FF8, 8'd3, 3'd2, 2'd1, -1);
        check("oor_rdata0", rd_data[0], 32'hB0);
        check("oor_rdata1", rd_data[1], 32'hB1);
        check("oor_rdata2", rd_data[2], 32'h0);
        check("oor_rdata3", rd_data[3], 32'h0);
        check("oor_rresp1", rd_resp[1], 2'b00);
        check("oor_rresp2", rd_resp[2], 2'b10);
        check("oor_rresp3", rd_resp[3], 2'b10);
        check("oor_rlast2", rd_last[2], 1'b0);
        check("oor_rlast3", rd_last[3], 1'b1);

        // Illegal size / reserved burst type: SLVERR, memory untouched
        wdata_v[0] = 32'hDEAD_BEEF; wstrb_v[0] = 4'hF;
        axi_write(16'h010, 8'd0, 3'd3, 2'd1, 0, resp);
        check("bad_size_bresp", resp, 2'b10);
        axi_write(16'h014, 8'd0, 3'd2, 2'd3, 0, resp);
        check("bad_type_bresp", resp, 2'b10);
        axi_read(16'h010, 8'd1, 3'd2, 2'd1, -1);
        check("bad_size_nowrite", rd_data[0], 32'hA0);
        check("bad_type_nowrite", rd_data[1], 32'hA1);

        // WLAST misplaced
        wdata_v[0] = 32'h5; wdata_v[1] = 32'h6; wstrb_v[0] = 4'hF; wstrb_v[1] = 4'hF;
        axi_write(16'h030, 8'd1, 3'd2, 2'd1, 0, resp);
        check("early_wlast_bresp", resp, 2'b10);
        axi_write(16'h030, 8'd0, 3'd2, 2'd1, -1, resp);
        check("missing_wlast_bresp", resp, 2'b10);

        // Illegal reads
        axi_read(16'h010, 8'd0, 3'd3, 2'd1, -1);
        check("bad_rsize_rresp", rd_resp[0], 2'b10);
        check("bad_rsize_rdata", rd_data[0], 32'h0);
        axi_read(16'h010, 8'd2, 3'd2, 2'd2, -1);
        check("bad_wrap_len_rresp", rd_resp[0], 2'b10);

        // RREADY stall mid-burst
        axi_read(16'h010, 8'd3, 3'd2, 2'd1, 1);
        for (int i = 0; i < 4; i++) check("stall_burst_rdata", rd_data[i], 32'hA0 + i);

        // Concurrent write and read over words 4..7: word 4 is read in the
        // same cycle it is written (old data); later beats see the new data.
        for (int i = 0; i < 4; i++) begin wdata_v[i] = 32'hD0 + i; wstrb_v[i] = 4'hF; end
        fork
            axi_write(16'h010, 8'd3, 3'd2, 2'd1, 3, resp_c);
            axi_read(16'h010, 8'd3, 3'd2, 2'd1, -1);
        join
        check("conc_bresp", resp_c, 2'b00);
        check("conc_rdata0", rd_data[0], 32'hA0);
        check("conc_rdata1", rd_data[1], 32'hD1);
        check("conc_rdata2", rd_data[2], 32'hD2);
        check("conc_rdata3", rd_data[3], 32'hD3);

        // Reset in the middle of a write burst after two beats
        AWADDR = 16'h050; AWLEN = 8'd3; AWSIZE = 3'd2; AWBURST = 2'd1; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        WDATA = 32'h11; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
        tick();
        WDATA = 32'h22;
        tick();
        WVALID = 1'b0;
        ARESETn = 1'b0;
        tick();
        check("mid_rst_bvalid", BVALID, 1'b0);
        check("mid_rst_wready", WREADY, 1'b0);
        ARESETn = 1'b1;
        tick();
        check("mid_rst_awready", AWREADY, 1'b1);
        check("mid_rst_bvalid_after", BVALID, 1'b0);
        wdata_v[0] = 32'h33; wdata_v[1] = 32'h44; wstrb_v[0] = 4'hF; wstrb_v[1] = 4'hF;
        axi_write(16'h060, 8'd1, 3'd2, 2'd1, 1, resp);
        check("post_rst_bresp", resp, 2'b00);
        axi_read(16'h050, 8'd1, 3'd2, 2'd1, -1);
        check("partial_write0", rd_data[0], 32'h11);
        check("partial_write1", rd_data[1], 32'h22);
        axi_read(16'h060, 8'd1, 3'd2, 2'd1, -1);
        check("post_rst_rdata0", rd_data[0], 32'h33);
        check("post_rst_rdata1", rd_data[1], 32'h44);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
